// File: rtl/magnetron_pkg.sv
// Shared state encoding and defaults for the magnetron cook controller.
package magnetron_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COOK   = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int unsigned DEFAULT_PERIOD = 10;

endpackage

// File: rtl/magnetron_if.sv
// Front-panel request / magnetron status bundle between panel decode and the cook controller.
interface magnetron_if #(
    parameter int unsigned TIME_W  = 16,
    parameter int unsigned POWER_W = 4
);
    logic               start;
    logic               stop;
    logic               door_open;
    logic [TIME_W-1:0]  time_load;
    logic [POWER_W-1:0] power;
    logic               mag_on;
    logic               busy;
    logic               done;
    logic [TIME_W-1:0]  time_left;

    modport master (
        output start, stop, door_open, time_load, power,
        input  mag_on, busy, done, time_left
    );

    modport slave (
        input  start, stop, door_open, time_load, power,
        output mag_on, busy, done, time_left
    );
endinterface

// File: rtl/magnetron_pwm.sv
// Duty-cycle phase counter; on_req is the next-cycle magnetron request for the given duty.
module magnetron_pwm
    import magnetron_pkg::*;
#(
    parameter int unsigned POWER_W = 4,
    parameter int unsigned PERIOD  = DEFAULT_PERIOD
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               advance,
    input  logic               cook_next,
    input  logic [POWER_W-1:0] duty_next,
    output logic [POWER_W:0]   next_phase,
    output logic               on_req
);
    localparam int unsigned PH_W = POWER_W + 1;
    localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(PERIOD - 1);

    logic [PH_W-1:0] phase_q;

    always_comb begin
        next_phase = phase_q;
        if (clear) begin
            next_phase = '0;
        end else if (advance) begin
            next_phase = (phase_q >= LAST_PHASE) ? '0 : phase_q + 1'b1;
        end
    end

    // One extra bit so duty values up to 2**POWER_W-1 compare cleanly against the phase.
    assign on_req = cook_next && (next_phase < {1'b0, duty_next});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
        end else begin
            phase_q <= next_phase;
        end
    end
endmodule

// File: rtl/magnetron_ctrl.sv
// Cook controller: door interlock, tick countdown and duty-cycled magnetron enable.
// Optional done-beep output enabled by defining MAGNETRON_BEEP_EN.
module magnetron_ctrl
    import magnetron_pkg::*;
#(
    parameter int unsigned TIME_W     = 16,
    parameter int unsigned POWER_W    = 4,
`ifdef MAGNETRON_BEEP_EN
    parameter int unsigned BEEP_TICKS = 500,
`endif
    parameter int unsigned PERIOD     = DEFAULT_PERIOD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
`ifdef MAGNETRON_BEEP_EN
    output logic       beep,
`endif
    magnetron_if.slave bus
);
    localparam logic [TIME_W-1:0] TIME_ONE = TIME_W'(1);

    state_e             state_q, state_d;
    logic [TIME_W-1:0]  time_q, time_d;
    logic [POWER_W-1:0] duty_q, duty_d;
    logic               phase_clear, phase_adv;
    logic [POWER_W:0]   next_phase;
    logic               on_req;
    logic               mag_on_q, busy_q, done_q;

    always_comb begin
        state_d     = state_q;
        time_d      = time_q;
        duty_d      = duty_q;
        phase_clear = 1'b0;
        phase_adv   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.stop && !bus.door_open && bus.time_load != '0) begin
                    state_d     = ST_COOK;
                    time_d      = bus.time_load;
                    duty_d      = bus.power;
                    phase_clear = 1'b1;
                end
            end
            ST_COOK: begin
                // Interlock and stop win over a coincident final tick.
                if (bus.stop || bus.door_open) begin
                    state_d = ST_PAUSED;
                end else if (tick) begin
                    phase_adv = 1'b1;
                    if (time_q <= TIME_ONE) begin
                        time_d  = '0;
                        state_d = ST_DONE;
                    end else begin
                        time_d = time_q - TIME_ONE;
                    end
                end
            end
            ST_PAUSED: begin
                if (bus.stop) begin
                    state_d = ST_IDLE;
                    time_d  = '0;
                end else if (bus.start && !bus.door_open) begin
                    state_d = ST_COOK;
                    duty_d  = bus.power;
                end
            end
            ST_DONE: begin
                if (bus.start || bus.stop || bus.door_open) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    magnetron_pwm #(
        .POWER_W (POWER_W),
        .PERIOD  (PERIOD)
    ) u_pwm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (phase_clear),
        .advance    (phase_adv),
        .cook_next  (state_d == ST_COOK),
        .duty_next  (duty_d),
        .next_phase (next_phase),
        .on_req     (on_req)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            time_q   <= '0;
            duty_q   <= '0;
            mag_on_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            time_q   <= time_d;
            duty_q   <= duty_d;
            mag_on_q <= on_req;
            busy_q   <= (state_d == ST_COOK) || (state_d == ST_PAUSED);
            done_q   <= (state_d == ST_DONE);
        end
    end

    assign bus.mag_on    = mag_on_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.time_left = time_q;

`ifdef MAGNETRON_BEEP_EN
    localparam int unsigned BEEP_W = $clog2(BEEP_TICKS + 1) + 1;

    logic [BEEP_W-1:0] beep_cnt_q, beep_cnt_d;
    logic              beep_q, beep_d;

    always_comb begin
        beep_cnt_d = beep_cnt_q;
        beep_d     = beep_q;
        if (state_d != ST_DONE) begin
            beep_d     = 1'b0;
            beep_cnt_d = '0;
        end else if (state_q != ST_DONE) begin
            beep_d     = (BEEP_TICKS != 0);
            beep_cnt_d = BEEP_W'(BEEP_TICKS);
        end else if (tick && beep_cnt_q != '0) begin
            beep_cnt_d = beep_cnt_q - 1'b1;
            if (beep_cnt_q == BEEP_W'(1)) begin
                beep_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beep_cnt_q <= '0;
            beep_q     <= 1'b0;
        end else begin
            beep_cnt_q <= beep_cnt_d;
            beep_q     <= beep_d;
        end
    end

    assign beep = beep_q;
`endif
endmodule
